// File: rtl/usrp_tag_chip_mtx_ctrl.sv
// Tag-chip MTX controller: pilot tone period followed by a stepped-frequency
// MTX symbol train, with front-panel GPIO strobes and halt control.
module usrp_tag_chip_mtx_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned NSYMB_WIDTH = 16,
  parameter int unsigned NSIG        = 8192,
  parameter int unsigned PILOT_NSIG  = 65536,
  parameter int unsigned NSYMB       = 24,
  parameter int unsigned REG_WIDTH   = 12,
  parameter logic [DATA_WIDTH-1:0]  AMP          = 16'h4000,
  parameter logic [PHASE_WIDTH-1:0] PILOT_PH_INC = 24'h010000,
  parameter logic [PHASE_WIDTH-1:0] MTX_PH_BASE  = 24'h004000,
  parameter logic [PHASE_WIDTH-1:0] MTX_PH_STEP  = 24'h000800
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_WIDTH-1:0]   fp_gpio_in,
  output logic [REG_WIDTH-1:0]   fp_gpio_out,
  output logic [REG_WIDTH-1:0]   fp_gpio_ddr,
  output logic [DATA_WIDTH-1:0]  itx,
  output logic [DATA_WIDTH-1:0]  qtx,
  output logic [DATA_WIDTH-1:0]  imtx,
  output logic [DATA_WIDTH-1:0]  qmtx,
  output logic                   tx_trig,
  output logic                   tx_valid,
  output logic [NSYMB_WIDTH-1:0] mtx_symbN,
  output logic [NSYMB_WIDTH-1:0] pilot_symbN,
  output logic [PHASE_WIDTH-1:0] mtx_sigN,
  output logic [PHASE_WIDTH-1:0] pilot_sigN,
  output logic [PHASE_WIDTH-1:0] mtx_ph,
  output logic [PHASE_WIDTH-1:0] pilot_ph
);

  typedef enum logic {
    PILOT = 1'b0,
    MTX   = 1'b1
  } state_t;

  localparam logic [DATA_WIDTH-1:0] NEG_AMP =
    DATA_WIDTH'(0) - AMP;
  localparam logic [PHASE_WIDTH-1:0] PILOT_LAST =
    PHASE_WIDTH'(PILOT_NSIG - 1);
  localparam logic [PHASE_WIDTH-1:0] MTX_LAST =
    PHASE_WIDTH'(NSIG - 1);
  localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST =
    NSYMB_WIDTH'(NSYMB - 1);

  state_t state;
  logic [PHASE_WIDTH-1:0] mtx_inc;
  logic in_mtx;
  logic unused_gpio;

  assign mtx_inc = MTX_PH_BASE
    + PHASE_WIDTH'(mtx_symbN) * MTX_PH_STEP;
  assign in_mtx = (state == MTX);
  assign unused_gpio = ^{fp_gpio_in[REG_WIDTH-1:9],
                         fp_gpio_in[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PILOT;
      tx_valid    <= 1'b0;
      pilot_sigN  <= '0;
      pilot_ph    <= '0;
      pilot_symbN <= '0;
      mtx_sigN    <= '0;
      mtx_symbN   <= '0;
      mtx_ph      <= '0;
    end else begin
      tx_valid <= ~fp_gpio_in[8];
      if (tx_valid) begin
        unique case (state)
          PILOT: begin
            if (pilot_sigN == PILOT_LAST) begin
              state       <= MTX;
              pilot_sigN  <= '0;
              pilot_ph    <= '0;
              pilot_symbN <= pilot_symbN + 1'b1;
            end else begin
              pilot_sigN <= pilot_sigN + 1'b1;
              pilot_ph   <= pilot_ph + PILOT_PH_INC;
            end
          end
          MTX: begin
            if (mtx_sigN == MTX_LAST) begin
              mtx_sigN <= '0;
              mtx_ph   <= '0;
              if (mtx_symbN == SYMB_LAST) begin
                mtx_symbN <= '0;
                state     <= PILOT;
              end else begin
                mtx_symbN <= mtx_symbN + 1'b1;
              end
            end else begin
              mtx_sigN <= mtx_sigN + 1'b1;
              mtx_ph   <= mtx_ph + mtx_inc;
            end
          end
          default: state <= PILOT;
        endcase
      end
    end
  end

  // Quadrant tone: I from the top phase bit, Q from the top two bits.
  logic [DATA_WIDTH-1:0] pilot_i, pilot_q, mtx_i, mtx_q;

  assign pilot_i = pilot_ph[PHASE_WIDTH-1] ? NEG_AMP : AMP;
  assign pilot_q = (pilot_ph[PHASE_WIDTH-1] ^ pilot_ph[PHASE_WIDTH-2])
                   ? NEG_AMP : AMP;
  assign mtx_i   = mtx_ph[PHASE_WIDTH-1] ? NEG_AMP : AMP;
  assign mtx_q   = (mtx_ph[PHASE_WIDTH-1] ^ mtx_ph[PHASE_WIDTH-2])
                   ? NEG_AMP : AMP;

  always_comb begin
    itx  = '0;
    qtx  = '0;
    imtx = '0;
    qmtx = '0;
    if (tx_valid) begin
      if (in_mtx) begin
        itx  = mtx_i;
        qtx  = mtx_q;
        imtx = mtx_i;
        qmtx = mtx_q;
      end else begin
        itx = pilot_i;
        qtx = pilot_q;
      end
    end
  end

  assign tx_trig = tx_valid && !in_mtx && (pilot_sigN == '0);

  assign fp_gpio_out = {
    {(REG_WIDTH-8){1'b0}},
    in_mtx && (mtx_sigN == '0),
    !in_mtx && tx_valid,
    in_mtx,
    mtx_symbN[4:0]
  };

  assign fp_gpio_ddr = REG_WIDTH'(12'h0FF);

endmodule

// File: tb/tb_usrp_tag_chip_mtx_ctrl.sv
// Directed bench for usrp_tag_chip_mtx_ctrl with a shortened frame
// (8 pilot samples, 3 symbols of 4 samples).
module tb_usrp_tag_chip_mtx_ctrl;

  logic        clk;
  logic        reset;
  logic [11:0] fp_gpio_in;
  logic [11:0] fp_gpio_out;
  logic [11:0] fp_gpio_ddr;
  logic [15:0] itx, qtx, imtx, qmtx;
  logic        tx_trig, tx_valid;
  logic [15:0] mtx_symbN, pilot_symbN;
  logic [23:0] mtx_sigN, pilot_sigN, mtx_ph, pilot_ph;

  int total = 0;
  int bad   = 0;

  usrp_tag_chip_mtx_ctrl #(
    .NSIG        (4),
    .PILOT_NSIG  (8),
    .NSYMB       (3),
    .PILOT_PH_INC(24'h200000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fp_gpio_in (fp_gpio_in),
    .fp_gpio_out(fp_gpio_out),
    .fp_gpio_ddr(fp_gpio_ddr),
    .itx        (itx),
    .qtx        (qtx),
    .imtx       (imtx),
    .qmtx       (qmtx),
    .tx_trig    (tx_trig),
    .tx_valid   (tx_valid),
    .mtx_symbN  (mtx_symbN),
    .pilot_symbN(pilot_symbN),
    .mtx_sigN   (mtx_sigN),
    .pilot_sigN (pilot_sigN),
    .mtx_ph     (mtx_ph),
    .pilot_ph   (pilot_ph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    fp_gpio_in = '0;
    step(3);
    total++;
    if (tx_valid !== 1'b0 || tx_trig !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got v=%b t=%b want 0 0",
               tx_valid, tx_trig);
    end
    total++;
    if (fp_gpio_out !== 12'h000 || fp_gpio_ddr !== 12'h0FF) begin
      bad++;
      $display("FAIL reset_gpio got out=%h ddr=%h want 000 0ff",
               fp_gpio_out, fp_gpio_ddr);
    end
    total++;
    if (itx !== 16'h0 || qtx !== 16'h0 || imtx !== 16'h0
        || qmtx !== 16'h0) begin
      bad++;
      $display("FAIL reset_tx got %h %h %h %h want 0",
               itx, qtx, imtx, qmtx);
    end
    total++;
    if (pilot_sigN !== 24'h0 || mtx_sigN !== 24'h0
        || pilot_symbN !== 16'h0 || mtx_symbN !== 16'h0
        || pilot_ph !== 24'h0 || mtx_ph !== 24'h0) begin
      bad++;
      $display("FAIL reset_cnt got ps=%h ms=%h pb=%h mb=%h pp=%h mp=%h",
               pilot_sigN, mtx_sigN, pilot_symbN, mtx_symbN,
               pilot_ph, mtx_ph);
    end
  endtask

  task automatic test_start;
    reset = 1'b1;
    step(1);
    total++;
    if (tx_valid !== 1'b1 || tx_trig !== 1'b1
        || pilot_sigN !== 24'h0) begin
      bad++;
      $display("FAIL start_trig got v=%b t=%b sig=%h want 1 1 0",
               tx_valid, tx_trig, pilot_sigN);
    end
    total++;
    if (itx !== 16'h4000 || qtx !== 16'h4000 || imtx !== 16'h0) begin
      bad++;
      $display("FAIL start_tone got i=%h q=%h im=%h want 4000 4000 0",
               itx, qtx, imtx);
    end
    total++;
    if (fp_gpio_out !== 12'h040) begin
      bad++;
      $display("FAIL start_gpio got %h want 040", fp_gpio_out);
    end
  endtask

  task automatic test_pilot_tone;
    step(2);
    total++;
    if (pilot_ph !== 24'h400000 || itx !== 16'h4000
        || qtx !== 16'hC000) begin
      bad++;
      $display("FAIL pilot_q2 got ph=%h i=%h q=%h want 400000 4000 c000",
               pilot_ph, itx, qtx);
    end
    step(2);
    total++;
    if (pilot_ph !== 24'h800000 || itx !== 16'hC000
        || qtx !== 16'hC000 || tx_trig !== 1'b0) begin
      bad++;
      $display("FAIL pilot_q3 got ph=%h i=%h q=%h t=%b want 800000 c000 c000 0",
               pilot_ph, itx, qtx, tx_trig);
    end
  endtask

  task automatic test_pilot_end;
    step(3);
    total++;
    if (pilot_sigN !== 24'd7 || fp_gpio_out !== 12'h040) begin
      bad++;
      $display("FAIL pilot_last got sig=%h gpio=%h want 7 040",
               pilot_sigN, fp_gpio_out);
    end
    step(1);
    total++;
    if (mtx_symbN !== 16'd0 || mtx_ph !== 24'h0 || mtx_sigN !== 24'h0
        || pilot_symbN !== 16'd1 || fp_gpio_out !== 12'h0A0) begin
      bad++;
      $display("FAIL mtx_entry got mb=%h mp=%h ms=%h pb=%h gpio=%h want 0 0 0 1 0a0",
               mtx_symbN, mtx_ph, mtx_sigN, pilot_symbN, fp_gpio_out);
    end
    total++;
    if (pilot_sigN !== 24'h0 || pilot_ph !== 24'h0
        || imtx !== 16'h4000 || itx !== 16'h4000) begin
      bad++;
      $display("FAIL mtx_entry_idle got ps=%h pp=%h im=%h i=%h want 0 0 4000 4000",
               pilot_sigN, pilot_ph, imtx, itx);
    end
    step(1);
    total++;
    if (mtx_sigN !== 24'd1 || mtx_ph !== 24'h004000
        || fp_gpio_out !== 12'h020) begin
      bad++;
      $display("FAIL mtx_sym0 got ms=%h mp=%h gpio=%h want 1 004000 020",
               mtx_sigN, mtx_ph, fp_gpio_out);
    end
  endtask

  task automatic test_mtx_sym2;
    logic [23:0] exp_ph;
    step(7);
    total++;
    if (mtx_symbN !== 16'd2 || mtx_sigN !== 24'h0
        || fp_gpio_out !== 12'h0A2) begin
      bad++;
      $display("FAIL sym2_start got mb=%h ms=%h gpio=%h want 2 0 0a2",
               mtx_symbN, mtx_sigN, fp_gpio_out);
    end
    exp_ph = 24'h0;
    for (int k = 1; k < 4; k++) begin
      step(1);
      exp_ph = exp_ph + 24'h005000;
      total++;
      if (mtx_ph !== exp_ph || fp_gpio_out !== 12'h022) begin
        bad++;
        $display("FAIL sym2_ph%0d got mp=%h gpio=%h want %h 022",
                 k, mtx_ph, fp_gpio_out, exp_ph);
      end
    end
    total++;
    if (tx_trig !== 1'b0) begin
      bad++;
      $display("FAIL trig_early got %b want 0", tx_trig);
    end
    step(1);
    total++;
    if (tx_trig !== 1'b1 || pilot_sigN !== 24'h0 || mtx_symbN !== 16'd0
        || pilot_symbN !== 16'd1 || fp_gpio_out !== 12'h040
        || imtx !== 16'h0) begin
      bad++;
      $display("FAIL frame_wrap got t=%b ps=%h mb=%h pb=%h gpio=%h im=%h want 1 0 0 1 040 0",
               tx_trig, pilot_sigN, mtx_symbN, pilot_symbN,
               fp_gpio_out, imtx);
    end
  endtask

  task automatic test_halt;
    step(10);
    total++;
    if (mtx_sigN !== 24'd2 || mtx_ph !== 24'h008000) begin
      bad++;
      $display("FAIL halt_pre got ms=%h mp=%h want 2 008000",
               mtx_sigN, mtx_ph);
    end
    fp_gpio_in = 12'h100;
    step(1);
    total++;
    if (tx_valid !== 1'b0 || mtx_sigN !== 24'd3
        || mtx_ph !== 24'h00C000) begin
      bad++;
      $display("FAIL halt_latency got v=%b ms=%h mp=%h want 0 3 00c000",
               tx_valid, mtx_sigN, mtx_ph);
    end
    step(3);
    total++;
    if (mtx_sigN !== 24'd3 || mtx_ph !== 24'h00C000
        || mtx_symbN !== 16'd0 || itx !== 16'h0 || qtx !== 16'h0
        || imtx !== 16'h0 || qmtx !== 16'h0
        || fp_gpio_out !== 12'h020) begin
      bad++;
      $display("FAIL halt_frozen got ms=%h mp=%h mb=%h i=%h q=%h im=%h qm=%h gpio=%h",
               mtx_sigN, mtx_ph, mtx_symbN, itx, qtx, imtx, qmtx,
               fp_gpio_out);
    end
    fp_gpio_in = 12'h000;
    step(1);
    total++;
    if (tx_valid !== 1'b1 || mtx_sigN !== 24'd3
        || itx !== 16'h4000 || qmtx !== 16'h4000) begin
      bad++;
      $display("FAIL halt_resume got v=%b ms=%h i=%h qm=%h want 1 3 4000 4000",
               tx_valid, mtx_sigN, itx, qmtx);
    end
    step(1);
    total++;
    if (mtx_symbN !== 16'd1 || mtx_sigN !== 24'h0
        || mtx_ph !== 24'h0) begin
      bad++;
      $display("FAIL halt_next got mb=%h ms=%h mp=%h want 1 0 0",
               mtx_symbN, mtx_sigN, mtx_ph);
    end
  endtask

  task automatic test_reset_mid;
    step(1);
    #2 reset = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || tx_trig !== 1'b0 || mtx_symbN !== 16'd0
        || mtx_sigN !== 24'h0 || pilot_symbN !== 16'd0
        || itx !== 16'h0 || imtx !== 16'h0
        || fp_gpio_out !== 12'h000 || fp_gpio_ddr !== 12'h0FF) begin
      bad++;
      $display("FAIL async_reset got v=%b t=%b mb=%h ms=%h pb=%h i=%h im=%h gpio=%h ddr=%h",
               tx_valid, tx_trig, mtx_symbN, mtx_sigN, pilot_symbN,
               itx, imtx, fp_gpio_out, fp_gpio_ddr);
    end
    step(2);
    reset = 1'b1;
    step(1);
    total++;
    if (tx_trig !== 1'b1 || pilot_symbN !== 16'd0
        || pilot_sigN !== 24'h0) begin
      bad++;
      $display("FAIL restart got t=%b pb=%h ps=%h want 1 0 0",
               tx_trig, pilot_symbN, pilot_sigN);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (tx_trig !== 1'b1 && n < 40);
    total++;
    if (n !== 20) begin
      bad++;
      $display("FAIL frame_len got %0d want 20", n);
    end
    total++;
    if (pilot_symbN !== 16'd1) begin
      bad++;
      $display("FAIL frame_count got %h want 1", pilot_symbN);
    end
  endtask

  initial begin
    test_reset;
    test_start;
    test_pilot_tone;
    test_pilot_end;
    test_mtx_sym2;
    test_halt;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usrp_tag_chip_mtx_ctrl.md
USRP_TAG_CHIP_MTX_CTRL -- requirements
Module: usrp_tag_chip_mtx_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH 16 sample width; PHASE_WIDTH 24 phase accumulator width; NSYMB_WIDTH 16 symbol counter width; NSIG 8192 samples per MTX symbol; PILOT_NSIG 65536 samples per pilot period; NSYMB 24 MTX symbols per frame; REG_WIDTH 12 GPIO width; AMP 16'h4000 tone amplitude; PILOT_PH_INC 24'h010000 pilot phase step; MTX_PH_BASE 24'h004000 MTX base phase step; MTX_PH_STEP 24'h000800 per-symbol step increment.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 clock; reset in 1 asynchronous active-low reset; fp_gpio_in in REG_WIDTH front-panel inputs; fp_gpio_out out REG_WIDTH tag-chip control; fp_gpio_ddr out REG_WIDTH GPIO direction (1=output); itx, qtx out DATA_WIDTH transmitted I/Q; imtx, qmtx out DATA_WIDTH MTX tone I/Q; tx_trig out 1 frame-start pulse; tx_valid out 1 sample valid; mtx_symbN, pilot_symbN out NSYMB_WIDTH; mtx_sigN, pilot_sigN out PHASE_WIDTH; mtx_ph, pilot_ph out PHASE_WIDTH.
REQ-003 SHALL use one clock clk; reset is asynchronous and active-low (reset=0 asserts); all state clears immediately on assertion.

Function
REQ-004 SHALL implement two states, PILOT and MTX; reset forces PILOT.
REQ-005 tx_valid SHALL be registered: tx_valid <= ~fp_gpio_in[8] each edge; counters, phases and state advance only on edges where tx_valid=1 (halt freezes all with one-cycle latency).
REQ-006 PILOT: pilot_sigN counts 0..PILOT_NSIG-1; pilot_ph starts 0, adds PILOT_PH_INC per advance (mod 2^PHASE_WIDTH); advance at pilot_sigN=PILOT_NSIG-1 -> MTX, pilot_sigN<=0, pilot_ph<=0, pilot_symbN+=1 (wraps at 2^NSYMB_WIDTH).
REQ-007 MTX: mtx_sigN counts 0..NSIG-1, mtx_symbN 0..NSYMB-1; mtx_ph starts 0 each symbol, adds MTX_PH_BASE + mtx_symbN*MTX_PH_STEP per advance (truncated to PHASE_WIDTH).
REQ-008 MTX advance at mtx_sigN=NSIG-1: mtx_sigN<=0, mtx_ph<=0; if mtx_symbN=NSYMB-1 then mtx_symbN<=0 and state -> PILOT, else mtx_symbN+=1.
REQ-009 Counters of the inactive state SHALL hold 0 (pilot_sigN, pilot_ph in MTX; mtx_sigN, mtx_symbN, mtx_ph in PILOT).
REQ-010 Frame length SHALL be PILOT_NSIG + NSYMB*NSIG advancing cycles.
REQ-011 Tone from phase p (combinational from registered p): I = +AMP if p[MSB]=0 else -AMP; Q = +AMP if p[MSB]^p[MSB-1]=0 else -AMP (two's complement).
REQ-012 imtx/qmtx SHALL be the tone of mtx_ph in MTX, 0 in PILOT; itx/qtx SHALL be tone of pilot_ph in PILOT, tone of mtx_ph in MTX; all four 0 while tx_valid=0.
REQ-013 tx_trig SHALL be combinational: 1 iff tx_valid=1, state=PILOT, pilot_sigN=0.
REQ-014 fp_gpio_out: [4:0]=mtx_symbN[4:0]; [5]=1 in MTX; [6]=1 in PILOT and tx_valid=1; [7]=1 when mtx_sigN=0 in MTX (symbol strobe); [REG_WIDTH-1:8]=0.
REQ-015 fp_gpio_ddr SHALL be constant 12'h0FF; fp_gpio_in bits other than [8] ignored.
REQ-016 Reset asserted mid-frame SHALL abort immediately; restart begins a fresh PILOT period.

Reset
REQ-017 During reset: tx_valid=0, tx_trig=0, state=PILOT, all counters/phases 0, itx/qtx/imtx/qmtx=0, fp_gpio_out=0, fp_gpio_ddr=12'h0FF.
REQ-018 First edge after release sets tx_valid=1 only; counting starts on the following edge.

Verification (NSIG=4, PILOT_NSIG=8, NSYMB=3, fp_gpio_in=0)
REQ-019 Release reset -> cycle 1: tx_trig=1, pilot_sigN=0, itx=16'h4000, qtx=16'h4000; tx_trig=1 again exactly 20 cycles later.
REQ-020 Pilot end -> after pilot_sigN=7: state MTX, mtx_symbN=0, mtx_ph=0, pilot_symbN=1, fp_gpio_out=12'h0A0.
REQ-021 MTX symbol 2 -> mtx_ph steps by 24'h005000 per cycle; fp_gpio_out[4:0]=2; after mtx_sigN=3 returns to PILOT.
REQ-022 Drive fp_gpio_in[8]=1 mid-MTX -> next cycle tx_valid=0, counters frozen, tx outputs 0; release resumes from frozen values.
REQ-023 Assert reset mid-MTX -> all outputs instantly at REQ-017 values; after release, pilot_symbN=0 and frame restarts.
REQ-024 pilot_ph crossing 24'h800000 -> itx flips to 16'hC000 (-AMP).
